// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate/arithmetic-shift/load/clear/hold with
// built-in serial-to-parallel framing (word + one-cycle word_valid).
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2:0]             mode,
  input  logic                   sin,
  input  logic [WIDTH-1:0]       pin,
  output logic [WIDTH-1:0]       out,
  output logic                   sout_l,
  output logic                   sout_r,
  output logic [WIDTH-1:0]       word,
  output logic                   word_valid,
  output logic [$clog2(WIDTH):0] bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_ASR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_next;
  logic             w_counted;
  logic             w_cnt_clr;

  always_comb begin
    w_next    = r_out;
    w_counted = 1'b0;
    w_cnt_clr = 1'b0;
    case (mode_e'(mode))
      M_SHL:  begin w_next = {r_out[WIDTH-2:0], sin}; w_counted = 1'b1; end
      M_SHR:  begin w_next = {sin, r_out[WIDTH-1:1]}; w_counted = 1'b1; end
      M_ROL:  w_next = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
      M_ROR:  w_next = {r_out[0], r_out[WIDTH-1:1]};
      M_LOAD: begin w_next = pin; w_cnt_clr = 1'b1; end
      M_CLR:  begin w_next = '0; w_cnt_clr = 1'b1; end
      M_ASR:  w_next = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
      default: w_next = r_out;
    endcase
  end

  // Load/clear take priority over frame completion, so a frame ending on the
  // same edge as a load is silently dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (en) begin
      r_out   <= w_next;
      r_valid <= 1'b0;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_counted) begin
        if (r_cnt == LAST) begin
          r_cnt   <= '0;
          r_word  <= w_next;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out        = r_out;
  assign sout_l     = r_out[WIDTH-1];
  assign sout_r     = r_out[0];
  assign word       = r_word;
  assign word_valid = r_valid;
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=4 and WIDTH=8 instances) with a
// queue-based scoreboard fed by a behavioural model of the register.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst;

  logic       en4, sin4;
  logic [2:0] mode4;
  logic [3:0] pin4, out4, word4;
  logic       soutl4, soutr4, valid4;
  logic [2:0] cnt4;

  logic       en8, sin8;
  logic [2:0] mode8;
  logic [7:0] pin8, out8, word8;
  logic       soutl8, soutr8, valid8;
  logic [3:0] cnt8;

  int n_assert = 0;
  int n_fail   = 0;

  shift_reg_univ #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .sin(sin4), .pin(pin4),
    .out(out4), .sout_l(soutl4), .sout_r(soutr4), .word(word4),
    .word_valid(valid4), .bit_cnt(cnt4)
  );

  shift_reg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin(sin8), .pin(pin8),
    .out(out8), .sout_l(soutl8), .sout_r(soutr8), .word(word8),
    .word_valid(valid8), .bit_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic [3:0] word;
    logic       valid;
    logic [2:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_out, m_word;
  logic       m_valid;
  logic [2:0] m_cnt;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_pop();
    exp_t x;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, "/out"},    {4'h0, out4},   {4'h0, x.out});
      chk({x.tag, "/word"},   {4'h0, word4},  {4'h0, x.word});
      chk({x.tag, "/valid"},  {7'h0, valid4}, {7'h0, x.valid});
      chk({x.tag, "/cnt"},    {5'h0, cnt4},   {5'h0, x.cnt});
      chk({x.tag, "/sout_l"}, {7'h0, soutl4}, {7'h0, x.out[3]});
      chk({x.tag, "/sout_r"}, {7'h0, soutr4}, {7'h0, x.out[0]});
    end
  endtask

  // Drive one cycle on the 4-bit instance, predict the result, then compare.
  task automatic step4(input logic e, input logic [2:0] m, input logic s,
                       input logic [3:0] p, input string tag);
    exp_t x;
    logic [3:0] nxt;
    en4 = e; mode4 = m; sin4 = s; pin4 = p;
    m_valid = 1'b0;
    if (e) begin
      case (m)
        3'b001:  nxt = {m_out[2:0], s};
        3'b010:  nxt = {s, m_out[3:1]};
        3'b011:  nxt = {m_out[2:0], m_out[3]};
        3'b100:  nxt = {m_out[0], m_out[3:1]};
        3'b101:  nxt = p;
        3'b110:  nxt = 4'b0000;
        3'b111:  nxt = {m_out[3], m_out[3:1]};
        default: nxt = m_out;
      endcase
      if (m == 3'b101 || m == 3'b110) begin
        m_cnt = 3'd0;
      end else if (m == 3'b001 || m == 3'b010) begin
        if (m_cnt == 3'd3) begin
          m_cnt   = 3'd0;
          m_word  = nxt;
          m_valid = 1'b1;
        end else begin
          m_cnt = m_cnt + 3'd1;
        end
      end
      m_out = nxt;
    end
    x.out = m_out; x.word = m_word; x.valid = m_valid; x.cnt = m_cnt; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic step8(input logic [2:0] m, input logic [7:0] p);
    en8 = 1'b1; mode8 = m; pin8 = p; sin8 = 1'b0;
    @(posedge clk);
    #1;
    en8 = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "/out4"},   {4'h0, out4},   8'h00);
    chk({tag, "/word4"},  {4'h0, word4},  8'h00);
    chk({tag, "/valid4"}, {7'h0, valid4}, 8'h00);
    chk({tag, "/cnt4"},   {5'h0, cnt4},   8'h00);
    chk({tag, "/out8"},   out8,           8'h00);
    chk({tag, "/cnt8"},   {4'h0, cnt8},   8'h00);
    m_out = '0; m_word = '0; m_valid = 1'b0; m_cnt = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] asr_exp [3];
    asr_exp[0] = 8'hC8; asr_exp[1] = 8'hE4; asr_exp[2] = 8'hF2;

    rst = 1'b0;
    en4 = 1'b0; mode4 = 3'b000; sin4 = 1'b0; pin4 = 4'h0;
    en8 = 1'b0; mode8 = 3'b000; sin8 = 1'b0; pin8 = 8'h00;
    #10;
    check_reset("reset_init");
    #10;
    rst = 1'b1;

    // Serial-in 1,0,1,1 then one hold to see the pulse drop
    step4(1, 3'b001, 1, 4'h0, "t1_s1");
    step4(1, 3'b001, 0, 4'h0, "t1_s2");
    step4(1, 3'b001, 1, 4'h0, "t1_s3");
    step4(1, 3'b001, 1, 4'h0, "t1_s4");
    chk("t1_word_const", {4'h0, word4}, 8'h0B);
    chk("t1_valid_const", {7'h0, valid4}, 8'h01);
    step4(1, 3'b000, 0, 4'h0, "t1_hold");

    // Load and rotate
    step4(1, 3'b101, 0, 4'b1001, "t2_load");
    step4(1, 3'b011, 0, 4'h0, "t2_rol1");
    chk("t2_rol1_const", {4'h0, out4}, 8'h03);
    step4(1, 3'b011, 0, 4'h0, "t2_rol2");
    chk("t2_rol2_const", {4'h0, out4}, 8'h06);
    step4(1, 3'b100, 0, 4'h0, "t2_ror");
    chk("t2_ror_const", {4'h0, out4}, 8'h03);

    // Arithmetic shift right on the 8-bit instance
    step8(3'b101, 8'h90);
    chk("t3_load", out8, 8'h90);
    for (int i = 0; i < 3; i++) begin
      step8(3'b111, 8'h00);
      chk($sformatf("t3_asr%0d", i), out8, asr_exp[i]);
      chk($sformatf("t3_sout_r%0d", i), {7'h0, soutr8}, 8'h00);
      chk($sformatf("t3_sout_l%0d", i), {7'h0, soutl8}, 8'h01);
    end
    chk("t3_cnt", {4'h0, cnt8}, 8'h00);

    // Enable gap inside a frame, then a load colliding with completion
    step4(1, 3'b110, 0, 4'h0, "t4_clr");
    step4(1, 3'b001, 1, 4'h0, "t4_s1");
    step4(1, 3'b010, 1, 4'h0, "t4_s2");
    step4(1, 3'b001, 0, 4'h0, "t4_s3");
    for (int i = 0; i < 5; i++) step4(0, 3'b001, 1, 4'hF, $sformatf("t4_frz%0d", i));
    chk("t4_frz_cnt", {5'h0, cnt4}, 8'h03);
    step4(1, 3'b001, 1, 4'h0, "t4_s4");
    chk("t4_pulse", {7'h0, valid4}, 8'h01);
    step4(1, 3'b001, 1, 4'h0, "t4_b1");
    step4(1, 3'b001, 0, 4'h0, "t4_b2");
    step4(1, 3'b001, 1, 4'h0, "t4_b3");
    step4(1, 3'b101, 1, 4'b1010, "t4_loadwin");
    chk("t4_loadwin_valid", {7'h0, valid4}, 8'h00);

    // Asynchronous reset mid-frame
    step4(1, 3'b001, 1, 4'h0, "t5_s1");
    step4(1, 3'b001, 0, 4'h0, "t5_s2");
    #3;
    rst = 1'b0;
    #1;
    check_reset("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step4(1, 3'b001, 1, 4'h0, $sformatf("t5_r%0d", i));
    chk("t5_word_const", {4'h0, word4}, 8'h0F);

    // Back-to-back right-shift frames of alternating bits
    step4(1, 3'b110, 0, 4'h0, "t6_clr");
    for (int i = 0; i < 12; i++) begin
      step4(1, 3'b010, logic'((i % 2) == 0), 4'h0, $sformatf("t6_e%0d", i + 1));
      if ((i % 4) == 3) chk($sformatf("t6_word%0d", i + 1), {4'h0, word4}, 8'h05);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
